overlap_add_stream: RTL and testbench

OVERLAP_ADD_STREAM -- requirements
Module: overlap_add_stream

---
 rtl/overlap_add_stream.sv | 149 ++++++++++++++
 tb/tb_overlap_add_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/overlap_add_stream.sv
// Streaming overlap-add for windowed IMDCT frames of 2*HALF_WINDOW_SIZE samples (HALF_WINDOW_SIZE a power of two).
// Define OVERLAP_SATURATE_EN to clamp the overlap sum; otherwise it wraps to WORD_LENGTH bits.
module overlap_add_stream #(
    parameter int HALF_WINDOW_SIZE = 512,
    parameter int WORD_LENGTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             sequence_pos,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WORD_LENGTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_done
);
    localparam int A_W = $clog2(HALF_WINDOW_SIZE);
    localparam int K_W = A_W + 1;
    localparam logic [K_W-1:0] K_HALF      = K_W'(HALF_WINDOW_SIZE);
    localparam logic [K_W-1:0] K_HALF_LAST = K_W'(HALF_WINDOW_SIZE - 1);
    localparam logic [K_W-1:0] K_LAST      = K_W'(2 * HALF_WINDOW_SIZE - 1);
    localparam logic [1:0]     POS_FIRST   = 2'd1;
    localparam logic [1:0]     POS_LAST    = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_OVERLAP, S_STORE, S_FLUSH} state_t;

    state_t                 r_state, w_state_nxt;
    logic [K_W-1:0]         r_k;
    logic [1:0]             r_pos;
    logic                   r_hist_valid;
    logic                   r_ready_en;
    logic                   r_out_valid;
    logic [WORD_LENGTH-1:0] r_out_data;
    logic                   r_frame_done;
    logic [WORD_LENGTH-1:0] r_hist [HALF_WINDOW_SIZE];

    logic                   w_in_ready, w_in_xfer, w_out_free;
    logic                   w_load_sum, w_load_hist, w_hist_wr;
    logic                   w_store_done, w_flush_done, w_add_hist;
    logic [1:0]             w_pos_eff;
    logic [A_W-1:0]         w_addr;
    logic [WORD_LENGTH-1:0] w_hist_rd, w_sum_out;
    logic [WORD_LENGTH:0]   w_sum;

    assign w_out_free   = !r_out_valid | out_ready;
    assign w_in_xfer    = in_valid & w_in_ready;
    assign w_store_done = w_hist_wr & (r_k == K_LAST);
    assign w_addr       = r_k[A_W-1:0];
    assign w_hist_rd    = r_hist[w_addr];
    assign w_pos_eff    = (r_state == S_IDLE) ? sequence_pos : r_pos;
    assign w_add_hist   = r_hist_valid & (w_pos_eff != POS_FIRST);
    assign w_sum        = {in_data[WORD_LENGTH-1], in_data}
                        + (w_add_hist ? {w_hist_rd[WORD_LENGTH-1], w_hist_rd} : '0);

`ifdef OVERLAP_SATURATE_EN
    // Overflow shows as the two top bits of the widened sum disagreeing.
    always_comb begin
        w_sum_out = w_sum[WORD_LENGTH-1:0];
        if (w_sum[WORD_LENGTH] != w_sum[WORD_LENGTH-1])
            w_sum_out = w_sum[WORD_LENGTH] ? {1'b1, {(WORD_LENGTH-1){1'b0}}}
                                           : {1'b0, {(WORD_LENGTH-1){1'b1}}};
    end
`else
    assign w_sum_out = w_sum[WORD_LENGTH-1:0];
`endif

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: default first in every always_comb so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_in_xfer) w_state_nxt = S_OVERLAP;
            S_OVERLAP: if (w_in_xfer && r_k == K_HALF_LAST) w_state_nxt = S_STORE;
            S_STORE:   if (w_store_done) w_state_nxt = (r_pos == POS_LAST) ? S_FLUSH : S_IDLE;
            S_FLUSH:   if (w_flush_done) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // IDLE also waits for a free output slot so a stalled sample is never overwritten.
    always_comb begin
        w_in_ready   = 1'b0;
        w_load_sum   = 1'b0;
        w_load_hist  = 1'b0;
        w_hist_wr    = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            S_IDLE, S_OVERLAP: begin
                w_in_ready = r_ready_en & w_out_free;
                w_load_sum = in_valid & w_in_ready;
            end
            S_STORE: begin
                w_in_ready = r_ready_en;
                w_hist_wr  = in_valid & w_in_ready;
            end
            S_FLUSH: begin
                w_load_hist  = (r_k < K_HALF) & w_out_free;
                w_flush_done = (r_k == K_HALF) & r_out_valid & out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k          <= '0;
            r_pos        <= '0;
            r_hist_valid <= 1'b0;
            r_ready_en   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_ready_en   <= 1'b1;
            r_frame_done <= (w_store_done & (r_pos != POS_LAST)) | w_flush_done;
            if (r_state == S_IDLE && w_in_xfer) r_pos <= sequence_pos;
            if (w_in_xfer)        r_k <= w_store_done ? '0 : r_k + K_W'(1);
            else if (w_load_hist) r_k <= r_k + K_W'(1);
            else if (w_flush_done) r_k <= '0;
            if (w_store_done)      r_hist_valid <= 1'b1;
            else if (w_flush_done) r_hist_valid <= 1'b0;
            if (w_load_sum) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sum_out;
            end else if (w_load_hist) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_hist_rd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // NOTE: history RAM has no reset; hist_valid alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (w_hist_wr) r_hist[w_addr] <= in_data;
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_overlap_add_stream.sv
// Directed bench for overlap_add_stream: first/middle/last frames, backpressure, mid-frame reset.
module tb_overlap_add_stream;
    localparam int HALF = 512;
    localparam int W    = 16;
`ifdef OVERLAP_SATURATE_EN
    localparam logic [W-1:0] SUM_7000 = 16'h7FFF;
`else
    localparam logic [W-1:0] SUM_7000 = 16'hE000;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   sequence_pos;
    logic [W-1:0] in_data;
    logic         in_valid, in_ready;
    logic [W-1:0] out_data;
    logic         out_valid, out_ready;
    logic         frame_done;

    overlap_add_stream #(.HALF_WINDOW_SIZE(HALF), .WORD_LENGTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .sequence_pos(sequence_pos),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           fd_count = 0;
    int           fd0 = 0;
    int           stall_viol = 0;
    logic         rand_ready = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [W-1:0] got_q[$];
    int           got_cyc[$];
    logic         dummy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs set; samples just before the rising edge.
    task automatic tick(output logic accepted);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #3;
        accepted = in_valid & in_ready;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_viol++;
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        if (frame_done) fd_count++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(dummy);
    endtask

    task automatic send_frame(input logic [1:0] pos, input logic [1:0] pos_later,
                              input int a, input int b, input int n);
        logic acc;
        int   guard;
        for (int k = 0; k < n; k++) begin
            in_valid     = 1'b1;
            in_data      = W'(a + b * k);
            sequence_pos = (k == 0) ? pos : pos_later;
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 1000) begin
                tick(acc);
                guard++;
            end
            if (!acc) begin
                check("accept_timeout", acc, 1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [1:0] pos, input logic [1:0] pos_later, input int a, input int b);
        got_q.delete();
        got_cyc.delete();
        fd0 = fd_count;
        send_frame(pos, pos_later, a, b, 2 * HALF);
        drain(4);
    endtask

    task automatic verify(input string tag, input int first, input int n, input int a, input int b);
        int           bad = 0;
        logic [W-1:0] e;
        for (int j = 0; j < n; j++) begin
            e = W'(a + b * j);
            if (got_q.size() <= first + j) bad++;
            else if (got_q[first + j] !== e) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; sequence_pos = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // First frame 1..1024: outputs 1..512 back to back, history becomes 513..1024.
        frame(2'd1, 2'd1, 1, 1);
        check("f1_count", got_q.size(), HALF);
        verify("f1_data", 0, HALF, 1, 1);
        check("f1_consecutive", got_cyc[HALF-1] - got_cyc[0], HALF - 1);
        check("f1_done", fd_count - fd0, 1);

        // Middle frame of 10s: 10 + 513..1024.
        frame(2'd0, 2'd0, 10, 0);
        check("f2_count", got_q.size(), HALF);
        verify("f2_data", 0, HALF, 523, 1);
        check("f2_done", fd_count - fd0, 1);

        // Position 3 acts as middle; a later change to 'last' is ignored.
        frame(2'd3, 2'd2, 0, 1);
        check("f3_count", got_q.size(), HALF);
        verify("f3_data", 0, HALF, 10, 1);
        check("f3_done", fd_count - fd0, 1);

        // Random backpressure: in 100+3k on history 512+k gives 612+4k.
        rand_ready = 1'b1;
        got_q.delete(); got_cyc.delete(); fd0 = fd_count;
        send_frame(2'd0, 2'd0, 100, 3, 2 * HALF);
        rand_ready = 1'b0; out_ready = 1'b1;
        drain(4);
        check("f4_count", got_q.size(), HALF);
        verify("f4_data", 0, HALF, 612, 4);
        check("f4_stall_stable", stall_viol, 0);
        check("f4_done", fd_count - fd0, 1);

        // First frame of 0x7000 loads the history, then a last frame overflows and flushes.
        frame(2'd1, 2'd1, 'h7000, 0);
        verify("f5_data", 0, HALF, 'h7000, 0);
        got_q.delete(); got_cyc.delete(); fd0 = fd_count;
        send_frame(2'd2, 2'd2, 'h7000, 0, 2 * HALF);
        check("f6_no_early_done", fd_count - fd0, 0);
        drain(2);
        check("f6_flush_in_ready", in_ready, 0);
        begin
            int g = 0;
            while (fd_count == fd0 && g < 3000) begin
                tick(dummy);
                g++;
            end
        end
        check("f6_done", fd_count - fd0, 1);
        check("f6_count", got_q.size(), 2 * HALF);
        verify("f6_sum", 0, HALF, SUM_7000, 0);
        verify("f6_flush", HALF, HALF, 'h7000, 0);
        drain(2);
        check("f6_idle_ready", in_ready, 1);
        check("f6_out_idle", out_valid, 0);

        // History is invalid after a flush: middle frame of 5s passes through.
        frame(2'd0, 2'd0, 5, 0);
        verify("f7_data", 0, HALF, 5, 0);

        // Reset at k=700 of a middle frame, then middle frames ignore then use history.
        got_q.delete();
        send_frame(2'd0, 2'd0, 7, 0, 700);
        reset_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        prev_stall = 1'b0;
        frame(2'd0, 2'd0, 5, 0);
        check("f8_count", got_q.size(), HALF);
        verify("f8_data", 0, HALF, 5, 0);
        check("f8_done", fd_count - fd0, 1);
        frame(2'd0, 2'd0, 0, 0);
        verify("f9_data", 0, HALF, 5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
